// File: rtl/ysyx_lsu_sb.sv
// ysyx_lsu_sb: load/store unit with a FIFO store buffer, a direct-mapped
// write-through L1D, and fence support.
//
// Ports:
//   clock, reset               clock and asynchronous active-low reset
//   fence_req / fence_done     level request to drain and invalidate / completion pulse
//   ren, raddr, ralu           load request (held until out_rvalid), address, load op
//   out_rdata, out_rvalid      aligned, extended load result and one-cycle completion pulse
//   wen, waddr, walu, wdata    store request (held until out_wready); walu[3:0] is the byte strobe
//   out_wready                 one-cycle store-accepted pulse
//   out_lsu_ar*, out_lsu_rstrb bus read request; bus_rdata / lsu_rvalid return it
//   out_lsu_aw*, out_lsu_w*    store-buffer drain port; lsu_wready completes the write
//   sb_count                   number of occupied store-buffer entries
module ysyx_lsu_sb #(
    parameter int XLEN     = 32,
    parameter int L1D_LEN  = 4,
    parameter int SB_DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      fence_req,
    output logic                      fence_done,
    input  logic                      ren,
    input  logic [XLEN-1:0]           raddr,
    input  logic [4:0]                ralu,
    output logic [XLEN-1:0]           out_rdata,
    output logic                      out_rvalid,
    input  logic                      wen,
    input  logic [XLEN-1:0]           waddr,
    input  logic [4:0]                walu,
    input  logic [XLEN-1:0]           wdata,
    output logic                      out_wready,
    output logic [XLEN-1:0]           out_lsu_araddr,
    output logic                      out_lsu_arvalid,
    output logic [7:0]                out_lsu_rstrb,
    input  logic [XLEN-1:0]           bus_rdata,
    input  logic                      lsu_rvalid,
    output logic [XLEN-1:0]           out_lsu_awaddr,
    output logic                      out_lsu_awvalid,
    output logic [XLEN-1:0]           out_lsu_wdata,
    output logic [7:0]                out_lsu_wstrb,
    output logic                      out_lsu_wvalid,
    input  logic                      lsu_wready,
    output logic [$clog2(SB_DEPTH):0] sb_count
);

    localparam int PW    = $clog2(SB_DEPTH);
    localparam int CW    = PW + 1;
    localparam int LINES = 1 << L1D_LEN;
    localparam int TW    = XLEN - L1D_LEN - 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(SB_DEPTH);

    localparam logic [4:0] YSYX_ALU_LB__ = 5'b00000;
    localparam logic [4:0] YSYX_ALU_LH__ = 5'b00001;
    localparam logic [4:0] YSYX_ALU_LW__ = 5'b00010;
    localparam logic [4:0] YSYX_ALU_LBU_ = 5'b00100;
    localparam logic [4:0] YSYX_ALU_LHU_ = 5'b00101;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_VALID} state_t;

    function automatic logic in_valid(input logic [XLEN-1:0] a);
        return (a >= 32'h0200_0048 && a < 32'h0200_0050) ||
               (a >= 32'h0f00_0000 && a < 32'h0f00_2000) ||
               (a >= 32'h1000_0000 && a < 32'h1002_0000) ||
               (a >= 32'h3000_0000 && a < 32'h4000_0000) ||
               (a >= 32'h8000_0000 && a < 32'h8040_0000) ||
               (a >= 32'ha000_0000 && a < 32'hd000_0000);
    endfunction

    function automatic logic in_uncached(input logic [XLEN-1:0] a);
        return (a >= 32'h0200_0048 && a < 32'h0200_0050) ||
               (a >= 32'h0c00_0000 && a < 32'h0d00_0000) ||
               (a >= 32'h1000_0000 && a < 32'h1002_0000) ||
               (a >= 32'ha000_0000 && a < 32'hb000_0000);
    endfunction

    // Shift the addressed byte/half down to bit 0, then extend per op.
    function automatic logic [XLEN-1:0] load_result(input logic [XLEN-1:0] word,
                                                    input logic [1:0] off,
                                                    input logic [4:0] op);
        logic [XLEN-1:0] sh;
        sh = word >> {off, 3'b000};
        case (op)
            YSYX_ALU_LB__: return {{(XLEN-8){sh[7]}}, sh[7:0]};
            YSYX_ALU_LBU_: return {{(XLEN-8){1'b0}}, sh[7:0]};
            YSYX_ALU_LH__: return {{(XLEN-16){sh[15]}}, sh[15:0]};
            YSYX_ALU_LHU_: return {{(XLEN-16){1'b0}}, sh[15:0]};
            default:       return sh;
        endcase
    endfunction

    function automatic logic [7:0] read_strb(input logic [4:0] op);
        case (op)
            YSYX_ALU_LB__, YSYX_ALU_LBU_: return 8'h01;
            YSYX_ALU_LH__, YSYX_ALU_LHU_: return 8'h03;
            default:                      return 8'h0f;
        endcase
    endfunction

    // Store buffer storage and control
    logic [XLEN-1:0]     sb_addr [SB_DEPTH];
    logic [XLEN-1:0]     sb_data [SB_DEPTH];
    logic [3:0]          sb_strb [SB_DEPTH];
    logic [SB_DEPTH-1:0] sb_vld;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic                drain_gap;
    logic                push, pop, drain_valid, conflict;

    // L1D storage
    logic [XLEN-1:0]  l1d_data [LINES];
    logic [TW-1:0]    l1d_tag  [LINES];
    logic [LINES-1:0] l1d_vld;

    state_t            state;
    logic [L1D_LEN-1:0] r_idx, d_idx;
    logic [TW-1:0]      r_tag, d_tag;
    logic               hit, fill, fill_same, tag_ok, merge_en;
    logic               fence_seen, fence_fire;
    logic [XLEN-1:0]    merge_base, merged;
    logic               unused_walu;

    assign unused_walu = walu[4];

    // The previous-cycle accept (out_wready) blocks a second push of the same held request.
    assign push        = wen && !out_wready && (sb_count < DEPTH_C) && !fence_req;
    // drain_gap keeps the next entry off the bus for one cycle after each pop.
    assign drain_valid = (sb_count != '0) && !drain_gap;
    assign pop         = drain_valid && lsu_wready;

    assign out_lsu_awvalid = drain_valid;
    assign out_lsu_wvalid  = drain_valid;
    assign out_lsu_awaddr  = drain_valid ? sb_addr[rd_ptr] : '0;
    assign out_lsu_wdata   = drain_valid ? sb_data[rd_ptr] : '0;
    assign out_lsu_wstrb   = drain_valid ? {4'b0, sb_strb[rd_ptr]} : 8'h00;

    assign r_idx = raddr[L1D_LEN+1:2];
    assign r_tag = raddr[XLEN-1:L1D_LEN+2];
    assign hit   = l1d_vld[r_idx] && (l1d_tag[r_idx] == r_tag);
    assign fill  = (state == S_BUS) && lsu_rvalid && in_valid(raddr) && !in_uncached(raddr);

    assign d_idx     = sb_addr[rd_ptr][L1D_LEN+1:2];
    assign d_tag     = sb_addr[rd_ptr][XLEN-1:L1D_LEN+2];
    assign fill_same = fill && (r_idx == d_idx);
    assign merge_en  = pop && tag_ok;

    assign fence_fire = fence_req && !fence_seen && (sb_count == '0) && (state == S_IDLE);

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++)
            if (sb_vld[i] && (sb_addr[i][XLEN-1:2] == raddr[XLEN-1:2]))
                conflict = 1'b1;
    end

    // A fill landing on the drained line this cycle becomes the merge base.
    always_comb begin
        merge_base = fill_same ? bus_rdata : l1d_data[d_idx];
        tag_ok     = fill_same ? (r_tag == d_tag)
                               : (l1d_vld[d_idx] && (l1d_tag[d_idx] == d_tag));
        merged     = merge_base;
        for (int b = 0; b < 4; b++)
            if (sb_strb[rd_ptr][b])
                merged[8*b +: 8] = sb_data[rd_ptr][8*b +: 8];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            sb_count   <= '0;
            sb_vld     <= '0;
            drain_gap  <= 1'b0;
            out_wready <= 1'b0;
        end else begin
            out_wready <= push;
            drain_gap  <= pop;
            if (push) begin
                sb_vld[wr_ptr] <= 1'b1;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                sb_vld[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PW'(1);
            end
            sb_count <= sb_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            sb_addr[wr_ptr] <= waddr;
            sb_data[wr_ptr] <= wdata;
            sb_strb[wr_ptr] <= walu[3:0];
        end
    end

    // Merge is written after the fill so it wins on a shared index.
    always_ff @(posedge clock) begin
        if (fill) begin
            l1d_data[r_idx] <= bus_rdata;
            l1d_tag[r_idx]  <= r_tag;
        end
        if (merge_en)
            l1d_data[d_idx] <= merged;
    end

    // fence_seen suppresses a second completion until fence_req drops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            l1d_vld    <= '0;
            fence_done <= 1'b0;
            fence_seen <= 1'b0;
        end else begin
            fence_done <= fence_fire;
            if (!fence_req)
                fence_seen <= 1'b0;
            else if (fence_fire)
                fence_seen <= 1'b1;
            if (fence_fire)
                l1d_vld <= '0;
            else if (fill)
                l1d_vld[r_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            out_rvalid      <= 1'b0;
            out_rdata       <= '0;
            out_lsu_arvalid <= 1'b0;
            out_lsu_araddr  <= '0;
            out_lsu_rstrb   <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ren && !conflict) begin
                        if (!in_valid(raddr)) begin
                            state      <= S_VALID;
                            out_rvalid <= 1'b1;
                            out_rdata  <= '0;
                        end else if (hit) begin
                            state      <= S_VALID;
                            out_rvalid <= 1'b1;
                            out_rdata  <= load_result(l1d_data[r_idx], raddr[1:0], ralu);
                        end else begin
                            state           <= S_BUS;
                            out_lsu_arvalid <= 1'b1;
                            out_lsu_araddr  <= raddr;
                            out_lsu_rstrb   <= read_strb(ralu);
                        end
                    end
                end
                S_BUS: begin
                    if (lsu_rvalid) begin
                        state           <= S_VALID;
                        out_rvalid      <= 1'b1;
                        out_rdata       <= load_result(bus_rdata, raddr[1:0], ralu);
                        out_lsu_arvalid <= 1'b0;
                        out_lsu_araddr  <= '0;
                        out_lsu_rstrb   <= 8'h00;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    out_rvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule
